key_sequence_lock: RTL and testbench
====================================

Name: key_sequence_lock

Overview:
- Consumes the debounced key stream (key_code 0-11 = A-L, one-cycle key_valid pulse) from the push-button front end.
- Collects SEQ_LEN keys into an entry buffer and compares the buffer against a programmable target code.
- Reports unlock or fail, counts consecutive failures, and enforces a timed lockout after MAX_FAIL failures.
- Sits between the button front end and the door/display control logic; runs on the 25 MHz system clock.

Parameters:
- SEQ_LEN, 4, number of keys per code entry (2..8).
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..7).
- TIMEOUT_CYCLES, 125000000, idle cycles between keys before a partial entry is discarded (5 s).
- LOCKOUT_CYCLES, 250000000, lockout duration in cycles (10 s).

Ports:
- clk, input, 1, system clock, 25 MHz.
- rst_n, input, 1, asynchronous active-low reset.
- key_code, input, 5, key index; values 0-11 are valid.
- key_valid, input, 1, one-cycle key-press strobe.
- clear, input, 1, level; abort the current entry.
- code_target, input, 4*SEQ_LEN, target code; nibble i holds the i-th key, with key 0 in bits [3:0].
- entered_keys, output, 4*SEQ_LEN, entry buffer, same packing as code_target.
- entry_cnt, output, 4, number of keys entered so far (0..SEQ_LEN).
- unlock, output, 1, one-cycle pulse on a correct code.
- fail, output, 1, one-cycle pulse on a wrong code.
- fail_cnt, output, 3, consecutive failure count.
- locked, output, 1, high while in LOCKOUT.

Behaviour:
- Reset: all outputs 0; entered_keys all 0; state IDLE; all counters 0.
- Key acceptance:
  - A key is accepted when key_valid=1, key_code<12, and state is IDLE or ENTRY.
  - Key codes of 12 or more are ignored and do not restart the timeout.
  - The key is written to nibble entry_cnt, key_code[3:0] only.
  - entry_cnt increments in the following cycle.
- States:
  - IDLE (entry_cnt=0): an accepted key moves to ENTRY; if SEQ_LEN=1, it goes directly to CHECK.
  - ENTRY:
    - Each accepted key restarts the timeout counter.
    - The key that brings the count to SEQ_LEN moves to CHECK.
    - The timeout counter reaching TIMEOUT_CYCLES-1 clears the buffer and entry_cnt and returns to IDLE. No fail pulse, fail_cnt unchanged.
  - CHECK (exactly one cycle):
    - Compares entered_keys against code_target, sampled in this cycle.
    - Match: unlock=1 next cycle, fail_cnt <= 0, go to IDLE.
    - Mismatch: fail=1 next cycle, fail_cnt+1. Go to LOCKOUT if the new count equals MAX_FAIL, otherwise IDLE.
    - Leaving CHECK clears entered_keys and entry_cnt.
    - key_valid during CHECK is dropped.
  - LOCKOUT:
    - locked=1 from the cycle fail pulses; keys and clear are ignored.
    - The counter runs to LOCKOUT_CYCLES-1, then fail_cnt <= 0, locked <= 0, go to IDLE.
- Latency: the last key strobe at cycle t gives CHECK at t+1 and unlock/fail at t+2. In the mismatch case, locked is also asserted at t+2.
- clear in IDLE/ENTRY:
  - Buffer and entry_cnt go to 0 next cycle, state IDLE, fail_cnt unchanged.
  - clear has priority over a simultaneous key_valid, and that key is discarded.
- unlock and fail are never both high. Each is high for exactly one cycle per check.
- Reset mid-operation (any state, including LOCKOUT) returns immediately to the reset values.
- Counter widths: timeout and lockout counters are $clog2 of their parameter, with a minimum of 1 bit. Counters saturate at terminal count rather than wrapping.

Decomposition:
- Shared package `keylock_pkg`:
  - state enum: IDLE, ENTRY, CHECK, LOCKOUT.
  - KEY_NUM=12, KEY_W=4.
  - key-letter constants KEY_A..KEY_L = 0..11, shared with the button front end.
- One sub-module, `cycle_timer`: loadable down-counter with a `done` flag. It is instantiated twice, once for the timeout and once for the lockout.

Test Plan:
All scenarios use SEQ_LEN=4, MAX_FAIL=3, TIMEOUT_CYCLES=10, LOCKOUT_CYCLES=20, and code_target=16'h3210 (A,B,C,D).
1. Keys 0,1,2,3 spaced 3 cycles apart -> unlock pulse exactly 2 cycles after the 4th key_valid; fail_cnt=0; entry_cnt back to 0.
2. Keys 0,1,2,4 -> fail pulse 2 cycles after the last key; fail_cnt=1; locked=0.
3. Three wrong entries in a row -> third fail gives fail_cnt=3 and locked=1 for 20 cycles. Keys sent during lockout are ignored (entry_cnt stays 0). After lockout, fail_cnt=0 and a correct code then unlocks.
4. Keys 0,1, then 12 idle cycles -> entry_cnt returns to 0 after 10 cycles with no fail pulse; new keys 0,1,2,3 then unlock.
5. key_code=13 strobed mid-entry -> ignored: entry_cnt unchanged, timeout not restarted.
6. clear asserted together with the 3rd key -> entry_cnt=0 next cycle and that key is discarded. A reset asserted in LOCKOUT -> locked=0 and fail_cnt=0 immediately.

Source files
------------

// File: rtl/keylock_pkg.sv
// Shared definitions for the key sequence lock and the push-button front end.
// Holds the controller state encoding, the key-width constants and the
// key-letter codes, so every block agrees on how keys A-L are numbered.
package keylock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    CHECK   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam int KEY_NUM = 12;
  localparam int KEY_W   = 4;

  localparam logic [KEY_W-1:0] KEY_A = 4'd0;
  localparam logic [KEY_W-1:0] KEY_B = 4'd1;
  localparam logic [KEY_W-1:0] KEY_C = 4'd2;
  localparam logic [KEY_W-1:0] KEY_D = 4'd3;
  localparam logic [KEY_W-1:0] KEY_E = 4'd4;
  localparam logic [KEY_W-1:0] KEY_F = 4'd5;
  localparam logic [KEY_W-1:0] KEY_G = 4'd6;
  localparam logic [KEY_W-1:0] KEY_H = 4'd7;
  localparam logic [KEY_W-1:0] KEY_I = 4'd8;
  localparam logic [KEY_W-1:0] KEY_J = 4'd9;
  localparam logic [KEY_W-1:0] KEY_K = 4'd10;
  localparam logic [KEY_W-1:0] KEY_L = 4'd11;

endpackage

// File: rtl/cycle_timer.sv
// Loadable saturating down-counter.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   load  - reload the counter with CYCLES-1
//   done  - high while the counter sits at zero
// After a load in cycle t, done rises CYCLES-1 cycles later, so a consumer
// acting on done leaves exactly CYCLES cycles after the load.
module cycle_timer #(
  parameter int unsigned CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/key_sequence_lock.sv
// Code-entry lock: collects SEQ_LEN keys, compares against code_target,
// pulses unlock/fail, counts consecutive failures and enforces a lockout.
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   key_code       - key index, 0-11 valid
//   key_valid      - one-cycle key strobe
//   clear          - abort current entry (level)
//   code_target    - target code, key i in nibble i
//   entered_keys   - entry buffer, same packing
//   entry_cnt      - keys entered so far
//   unlock, fail   - one-cycle result pulses
//   fail_cnt       - consecutive failure count
//   locked         - high during lockout
//
// state   | meaning
// IDLE    | no keys held, waiting for first key
// ENTRY   | partial entry held, timeout running
// CHECK   | one cycle, buffer compared with target
// LOCKOUT | too many failures, input ignored until timer expires
module key_sequence_lock
  import keylock_pkg::*;
#(
  parameter int SEQ_LEN        = 4,
  parameter int MAX_FAIL       = 3,
  parameter int TIMEOUT_CYCLES = 125000000,
  parameter int LOCKOUT_CYCLES = 250000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4:0]               key_code,
  input  logic                     key_valid,
  input  logic                     clear,
  input  logic [KEY_W*SEQ_LEN-1:0] code_target,
  output logic [KEY_W*SEQ_LEN-1:0] entered_keys,
  output logic [3:0]               entry_cnt,
  output logic                     unlock,
  output logic                     fail,
  output logic [2:0]               fail_cnt,
  output logic                     locked
);

  state_t     state, state_nxt;
  logic       key_ok, accept, last_key, code_match, hit_max;
  logic       t_done, l_done, l_load, timed_out;
  logic [2:0] fail_cnt_inc;

  // Codes 12+ are ignored entirely, including for restarting the timeout.
  assign key_ok       = key_valid && (key_code < 5'(KEY_NUM));
  assign accept       = key_ok && !clear && (state == IDLE || state == ENTRY);
  assign last_key     = (entry_cnt == 4'(SEQ_LEN - 1));
  assign code_match   = (entered_keys == code_target);
  assign fail_cnt_inc = fail_cnt + 3'd1;
  assign hit_max      = (fail_cnt_inc == 3'(MAX_FAIL));
  assign l_load       = (state == CHECK) && !code_match && hit_max;
  // A key arriving on the expiry cycle wins and restarts the timer.
  assign timed_out    = (state == ENTRY) && !accept && !clear && t_done;

  cycle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .done  (t_done)
  );

  cycle_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (l_load),
    .done  (l_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (SEQ_LEN == 1) ? CHECK : ENTRY;
      end
      ENTRY: begin
        if (clear)                  state_nxt = IDLE;
        else if (accept && last_key) state_nxt = CHECK;
        else if (timed_out)         state_nxt = IDLE;
      end
      CHECK: begin
        if (!code_match && hit_max) state_nxt = LOCKOUT;
        else                        state_nxt = IDLE;
      end
      LOCKOUT: begin
        if (l_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    locked = 1'b0;
    if (state == LOCKOUT) locked = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entered_keys <= '0;
      entry_cnt    <= '0;
      unlock       <= 1'b0;
      fail         <= 1'b0;
      fail_cnt     <= '0;
    end else begin
      unlock <= 1'b0;
      fail   <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (clear || timed_out) begin
            entered_keys <= '0;
            entry_cnt    <= '0;
          end else if (accept) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
              if (entry_cnt == 4'(i)) entered_keys[i*KEY_W +: KEY_W] <= key_code[KEY_W-1:0];
            end
            entry_cnt <= entry_cnt + 4'd1;
          end
        end
        CHECK: begin
          entered_keys <= '0;
          entry_cnt    <= '0;
          if (code_match) begin
            unlock   <= 1'b1;
            fail_cnt <= '0;
          end else begin
            fail     <= 1'b1;
            fail_cnt <= fail_cnt_inc;
          end
        end
        LOCKOUT: begin
          if (l_done) fail_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sequence_lock.sv
// Scoreboard bench for key_sequence_lock with a small timing setup:
// SEQ_LEN=4, MAX_FAIL=3, TIMEOUT_CYCLES=10, LOCKOUT_CYCLES=20, target A,B,C,D.
module tb_key_sequence_lock;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  key_code = '0;
  logic        key_valid = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] code_target = 16'h3210;
  logic [15:0] entered_keys;
  logic [3:0]  entry_cnt;
  logic        unlock, fail, locked;
  logic [2:0]  fail_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int         kind;   // 1 = unlock, 2 = fail
    int         cyc;
    logic [2:0] fcnt;
    logic       lck;
  } exp_t;
  exp_t sb_q[$];

  key_sequence_lock #(
    .SEQ_LEN(4), .MAX_FAIL(3), .TIMEOUT_CYCLES(10), .LOCKOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .clear(clear), .code_target(code_target), .entered_keys(entered_keys),
    .entry_cnt(entry_cnt), .unlock(unlock), .fail(fail), .fail_cnt(fail_cnt),
    .locked(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every result pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && (unlock || fail)) begin
      chk("pulse_exclusive", {31'd0, unlock && fail}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, fail, unlock}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("pulse_kind", unlock ? 32'd1 : 32'd2, 32'(e.kind));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_fail_cnt", {29'd0, fail_cnt}, {29'd0, e.fcnt});
        chk("pulse_locked", {31'd0, locked}, {31'd0, e.lck});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one key; if a result is expected, it must appear 2 cycles later.
  task automatic send_key(input logic [4:0] k, input int kind, input logic [2:0] ef, input logic el);
    exp_t e;
    key_code  = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    if (kind != 0) begin
      e.kind = kind; e.cyc = cyc + 1; e.fcnt = ef; e.lck = el;
      sb_q.push_back(e);
    end
  endtask

  task automatic entry(input logic [15:0] code, input int kind, input logic [2:0] ef, input logic el);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) send_key({1'b0, code[i*4 +: 4]}, kind, ef, el);
      else begin
        send_key({1'b0, code[i*4 +: 4]}, 0, 3'd0, 1'b0);
        tick(); tick();
      end
    end
    tick(); tick(); tick();
  endtask

  int lock_cycles;

  initial begin
    tick(); tick(); tick();
    chk("rst_entered", 32'(entered_keys), 32'd0);
    chk("rst_entry_cnt", 32'(entry_cnt), 32'd0);
    chk("rst_pulses", {30'd0, unlock, fail}, 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: correct code, keys 3 cycles apart
    send_key(5'd0, 0, 3'd0, 1'b0);
    chk("s1_cnt1", 32'(entry_cnt), 32'd1);
    tick(); tick();
    send_key(5'd1, 0, 3'd0, 1'b0);
    chk("s1_buf2", 32'(entered_keys), 32'h0010);
    tick(); tick();
    send_key(5'd2, 0, 3'd0, 1'b0);
    chk("s1_cnt3", 32'(entry_cnt), 32'd3);
    chk("s1_buf3", 32'(entered_keys), 32'h0210);
    tick(); tick();
    send_key(5'd3, 1, 3'd0, 1'b0);
    chk("s1_cnt4", 32'(entry_cnt), 32'd4);
    tick(); tick(); tick();
    chk("s1_cnt_after", 32'(entry_cnt), 32'd0);
    chk("s1_buf_after", 32'(entered_keys), 32'd0);

    // 2: wrong code
    entry(16'h4210, 2, 3'd1, 1'b0);
    chk("s2_fail_cnt", 32'(fail_cnt), 32'd1);
    chk("s2_locked", 32'(locked), 32'd0);

    // 3: two more failures -> lockout
    entry(16'h5210, 2, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_key({1'b0, 4'(i)}, 0, 3'd0, 1'b0);
      tick(); tick();
    end
    send_key(5'd7, 2, 3'd3, 1'b1);
    lock_cycles = 0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          @(negedge clk);
          if (locked) lock_cycles++;
        end
      end
      begin
        tick(); tick(); tick(); tick();
        send_key(5'd0, 0, 3'd0, 1'b0);
        chk("s3_key_ignored", 32'(entry_cnt), 32'd0);
        chk("s3_mid_fail_cnt", 32'(fail_cnt), 32'd3);
        chk("s3_mid_locked", 32'(locked), 32'd1);
        tick();
        send_key(5'd1, 0, 3'd0, 1'b0);
        chk("s3_key_ignored2", 32'(entry_cnt), 32'd0);
      end
    join
    tick();
    chk("s3_lock_len", 32'(lock_cycles), 32'd20);
    chk("s3_fail_cnt_after", 32'(fail_cnt), 32'd0);
    chk("s3_locked_after", 32'(locked), 32'd0);
    entry(16'h3210, 1, 3'd0, 1'b0);

    // 4: partial entry times out, no fail pulse
    send_key(5'd0, 0, 3'd0, 1'b0);
    send_key(5'd1, 0, 3'd0, 1'b0);
    repeat (9) tick();
    chk("s4_before_to", 32'(entry_cnt), 32'd2);
    tick();
    chk("s4_timeout", 32'(entry_cnt), 32'd0);
    chk("s4_buf_cleared", 32'(entered_keys), 32'd0);
    tick(); tick();
    entry(16'h3210, 1, 3'd0, 1'b0);

    // 5: invalid key code is ignored and does not restart the timeout
    send_key(5'd0, 0, 3'd0, 1'b0);
    send_key(5'd1, 0, 3'd0, 1'b0);
    tick(); tick();
    send_key(5'd13, 0, 3'd0, 1'b0);
    chk("s5_bad_key_cnt", 32'(entry_cnt), 32'd2);
    chk("s5_bad_key_buf", 32'(entered_keys), 32'h0010);
    repeat (6) tick();
    chk("s5_before_to", 32'(entry_cnt), 32'd2);
    tick();
    chk("s5_timeout_kept", 32'(entry_cnt), 32'd0);
    tick();

    // 6a: clear with the 3rd key discards it
    send_key(5'd0, 0, 3'd0, 1'b0);
    send_key(5'd1, 0, 3'd0, 1'b0);
    clear = 1'b1;
    send_key(5'd2, 0, 3'd0, 1'b0);
    clear = 1'b0;
    chk("s6_clear_cnt", 32'(entry_cnt), 32'd0);
    chk("s6_clear_buf", 32'(entered_keys), 32'd0);
    chk("s6_clear_fail_cnt", 32'(fail_cnt), 32'd0);
    tick();
    entry(16'h3210, 1, 3'd0, 1'b0);

    // 6b: reset during lockout
    entry(16'h1111, 2, 3'd1, 1'b0);
    entry(16'h2222, 2, 3'd2, 1'b0);
    entry(16'h3333, 2, 3'd3, 1'b1);
    tick(); tick();
    chk("s6_pre_rst_locked", 32'(locked), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_locked", 32'(locked), 32'd0);
    chk("s6_rst_fail_cnt", 32'(fail_cnt), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    entry(16'h3210, 1, 3'd0, 1'b0);

    tick(); tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
